// File: rtl/jtag_ir_pkg.sv
// Shared definitions for the parametrised JTAG instruction register: instruction
// indices, opcode map and the opcode decoder function.
package jtag_ir_pkg;

  typedef enum logic [3:0] {
    BYPASS,
    SAMPLE_PRELOAD,
    EXTEST,
    INTEST,
    IDCODE,
    CLAMP,
    HALT,
    STEP,
    RESUME,
    RESET
  } instr_idx_e;

  localparam logic [1:0] CAPTURE_LSBS = 2'b01;
  localparam int MAX_W    = 8;
  localparam int MAX_INST = 1 << MAX_W;

  typedef struct packed {
    logic                legal;
    logic [MAX_INST-1:0] onehot;
  } decode_t;

  // BYPASS is all ones and EXTEST all zeros; every other index is its own opcode.
  function automatic logic [MAX_W-1:0] opcode_of(input int idx, input int width);
    logic [MAX_W-1:0] ones;
    ones = {MAX_W{1'b1}} >> (MAX_W - width);
    if (idx == int'(BYPASS)) return ones;
    if (idx == int'(EXTEST)) return '0;
    return MAX_W'(idx) & ones;
  endfunction

  function automatic decode_t decode(input logic [MAX_W-1:0] code, input int width,
                                     input int count);
    decode_t d;
    d = '0;
    for (int k = 0; k < count; k++) begin
      if (!d.legal && opcode_of(k, width) == code) begin
        d.legal     = 1'b1;
        d.onehot[k] = 1'b1;
      end
    end
    // Unmapped codes fall through to BYPASS so the bus is never empty.
    if (!d.legal) d.onehot[int'(BYPASS)] = 1'b1;
    return d;
  endfunction

endpackage

// File: rtl/jtag_ir_if.sv
// TAP-side signal bundle of the instruction register: controller strobes in,
// serial/decoded instruction and error flags out.
interface jtag_ir_if #(
  parameter int IR_WIDTH   = 4,
  parameter int INST_COUNT = 10
);
  logic                  tdi;
  logic                  capture_ir;
  logic                  shift_ir;
  logic                  update_ir;
  logic [IR_WIDTH-3:0]   status_i;
  logic                  tdo;
  logic                  tdo_en;
  logic [INST_COUNT-1:0] instr_onehot;
  logic [IR_WIDTH-1:0]   instr_code;
  logic                  illegal_o;
  logic                  len_err_o;
  logic                  parity_err_o;

  modport master (
    output tdi, capture_ir, shift_ir, update_ir, status_i,
    input  tdo, tdo_en, instr_onehot, instr_code, illegal_o, len_err_o, parity_err_o
  );

  modport slave (
    input  tdi, capture_ir, shift_ir, update_ir, status_i,
    output tdo, tdo_en, instr_onehot, instr_code, illegal_o, len_err_o, parity_err_o
  );
endinterface

// File: rtl/jtag_ir_decoder.sv
// Combinational opcode -> one-hot instruction decoder; also used by the
// boundary-scan controller.
module jtag_ir_decoder
  import jtag_ir_pkg::*;
#(
  parameter int IR_WIDTH   = 4,
  parameter int INST_COUNT = 10
) (
  input  logic [IR_WIDTH-1:0]   code,
  output logic                  legal,
  output logic [INST_COUNT-1:0] onehot
);

  decode_t dec;
  logic    unused_hi;

  always_comb begin
    dec    = decode(MAX_W'(code), IR_WIDTH, INST_COUNT);
    legal  = dec.legal;
    onehot = dec.onehot[INST_COUNT-1:0];
  end

  assign unused_hi = ^dec.onehot[MAX_INST-1:INST_COUNT];

endmodule

// File: rtl/jtag_ir_param.sv
// Parametrised JTAG instruction register: capture/shift chain on posedge tck,
// TDO and update on negedge. Optional parity bit with `JTAG_IR_PARITY_EN.
module jtag_ir_param
  import jtag_ir_pkg::*;
#(
  parameter int IR_WIDTH   = 4,
  parameter int INST_COUNT = 10,
  parameter int RESET_INST = 4
) (
  input logic       tck,
  input logic       tl_reset,
  jtag_ir_if.slave  bus
);

`ifdef JTAG_IR_PARITY_EN
  localparam int CL = IR_WIDTH + 1;
`else
  localparam int CL = IR_WIDTH;
`endif
  localparam int                   CNT_W       = $clog2(CL + 2);
  localparam logic [MAX_W-1:0]     RESET_CODE  = opcode_of(RESET_INST, IR_WIDTH);
  localparam logic [IR_WIDTH-1:0]  BYPASS_CODE = '1;

  logic [CL-1:0]         chain;
  logic [CNT_W-1:0]      cnt;
  logic                  shift_p0;
  logic                  dec_legal;
  logic [INST_COUNT-1:0] dec_onehot;
  logic                  parity_bad;

  logic                  tdo_p1;
  logic                  tdo_en_p1;
  logic [INST_COUNT-1:0] onehot_p1;
  logic [IR_WIDTH-1:0]   code_p1;
  logic                  illegal_p1;
  logic                  len_err_p1;
  logic                  par_err_p1;

  // Posedge stage: capture/shift chain and shift-length counter
  always_ff @(posedge tck or posedge tl_reset) begin
    if (tl_reset) begin
      chain    <= CL'(CAPTURE_LSBS);
      cnt      <= '0;
      shift_p0 <= 1'b0;
    end else begin
      shift_p0 <= bus.shift_ir;
      if (bus.capture_ir) begin
        chain <= CL'({bus.status_i, CAPTURE_LSBS});
        cnt   <= '0;
      end else if (bus.shift_ir) begin
        chain <= {bus.tdi, chain[CL-1:1]};
        if (cnt != CNT_W'(CL + 1)) cnt <= cnt + 1'b1;
      end
    end
  end

  jtag_ir_decoder #(
    .IR_WIDTH  (IR_WIDTH),
    .INST_COUNT(INST_COUNT)
  ) u_dec (
    .code  (chain[IR_WIDTH-1:0]),
    .legal (dec_legal),
    .onehot(dec_onehot)
  );

`ifdef JTAG_IR_PARITY_EN
  // The parity bit must carry the XOR of the opcode bits.
  assign parity_bad = chain[IR_WIDTH] != ^chain[IR_WIDTH-1:0];
`else
  assign parity_bad = 1'b0;
`endif

  // Negedge stage: TDO retiming and instruction update
  always_ff @(negedge tck or posedge tl_reset) begin
    if (tl_reset) begin
      tdo_p1     <= 1'b0;
      tdo_en_p1  <= 1'b0;
      onehot_p1  <= INST_COUNT'(1) << RESET_INST;
      code_p1    <= RESET_CODE[IR_WIDTH-1:0];
      illegal_p1 <= 1'b0;
      len_err_p1 <= 1'b0;
      par_err_p1 <= 1'b0;
    end else begin
      tdo_p1    <= chain[0];
      tdo_en_p1 <= shift_p0;
      if (bus.update_ir) begin
        len_err_p1 <= cnt != CNT_W'(CL);
        if (parity_bad) begin
          onehot_p1  <= INST_COUNT'(1) << int'(BYPASS);
          code_p1    <= BYPASS_CODE;
          illegal_p1 <= 1'b0;
          par_err_p1 <= 1'b1;
        end else begin
          onehot_p1  <= dec_onehot;
          code_p1    <= dec_legal ? chain[IR_WIDTH-1:0] : BYPASS_CODE;
          illegal_p1 <= !dec_legal;
          par_err_p1 <= 1'b0;
        end
      end
    end
  end

  assign bus.tdo          = tdo_p1;
  assign bus.tdo_en       = tdo_en_p1;
  assign bus.instr_onehot = onehot_p1;
  assign bus.instr_code   = code_p1;
  assign bus.illegal_o    = illegal_p1;
  assign bus.len_err_o    = len_err_p1;
  assign bus.parity_err_o = par_err_p1;

endmodule

// File: tb/tb_jtag_ir_param.sv
// Bench for jtag_ir_param: reset/table/directed sequences plus random TAP
// traffic checked against a bit-queue model of the instruction register.
module tb_jtag_ir_param;

  localparam int IRW   = 4;
  localparam int IC    = 10;
  localparam int RST_I = 4;
`ifdef JTAG_IR_PARITY_EN
  localparam int CL = IRW + 1;
`else
  localparam int CL = IRW;
`endif

  logic tck = 1'b0;
  logic tl_reset;

  jtag_ir_if #(.IR_WIDTH(IRW), .INST_COUNT(IC)) bus ();

  jtag_ir_param #(
    .IR_WIDTH  (IRW),
    .INST_COUNT(IC),
    .RESET_INST(RST_I)
  ) dut (
    .tck     (tck),
    .tl_reset(tl_reset),
    .bus     (bus)
  );

  always #5 tck = ~tck;

  int errors = 0;
  int checks = 0;

  // Reference model: chain held as a queue of bits, element 0 = chain bit 0.
  bit              q[$];
  int              m_cnt;
  bit              m_shp;
  logic            m_tdo, m_tdo_en, m_ill, m_len, m_par;
  logic [IC-1:0]   m_onehot;
  logic [IRW-1:0]  m_code;
  int              opc[IC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    q.delete();
    q.push_back(1'b1);
    for (int i = 1; i < CL; i++) q.push_back(1'b0);
    m_cnt    = 0;
    m_shp    = 0;
    m_tdo    = 0;
    m_tdo_en = 0;
    m_onehot = IC'(1) << RST_I;
    m_code   = IRW'(opc[RST_I]);
    m_ill    = 0;
    m_len    = 0;
    m_par    = 0;
  endtask

  task automatic m_capture(input logic [IRW-3:0] st);
    q.delete();
    q.push_back(1'b1);
    q.push_back(1'b0);
    for (int i = 0; i < IRW - 2; i++) q.push_back(st[i]);
    if (CL > IRW) q.push_back(1'b0);
    m_cnt = 0;
  endtask

  task automatic m_update();
    int v;
    int ones;
    int hit;
    bit bad;
    v = 0; ones = 0; hit = -1; bad = 0;
    for (int i = 0; i < IRW; i++) begin
      v    += int'(q[i]) << i;
      ones += int'(q[i]);
    end
    if (CL > IRW) bad = (q[IRW] != ones[0]);
    m_len = (m_cnt != CL);
    if (bad) begin
      m_onehot = IC'(1);
      m_code   = '1;
      m_ill    = 0;
      m_par    = 1;
    end else begin
      for (int i = 0; i < IC; i++) if (hit < 0 && opc[i] == v) hit = i;
      m_par = 0;
      if (hit < 0) begin
        m_onehot = IC'(1);
        m_code   = '1;
        m_ill    = 1;
      end else begin
        m_onehot = IC'(1) << hit;
        m_code   = IRW'(v);
        m_ill    = 0;
      end
    end
  endtask

  // One tck period: drive, model posedge, model negedge, settle past negedge.
  task automatic cyc(input bit c, input bit s, input bit u, input bit d,
                     input logic [IRW-3:0] st);
    bus.capture_ir = c;
    bus.shift_ir   = s;
    bus.update_ir  = u;
    bus.tdi        = d;
    bus.status_i   = st;
    @(posedge tck);
    if (c) m_capture(st);
    else if (s) begin
      q.push_back(d);
      void'(q.pop_front());
      if (m_cnt < CL + 1) m_cnt++;
    end
    m_shp = s;
    @(negedge tck);
    m_tdo    = q[0];
    m_tdo_en = m_shp;
    if (u) m_update();
    #1;
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".tdo"},     32'(bus.tdo),          32'(m_tdo));
    chk({tag, ".tdo_en"},  32'(bus.tdo_en),       32'(m_tdo_en));
    chk({tag, ".onehot"},  32'(bus.instr_onehot), 32'(m_onehot));
    chk({tag, ".code"},    32'(bus.instr_code),   32'(m_code));
    chk({tag, ".illegal"}, 32'(bus.illegal_o),    32'(m_ill));
    chk({tag, ".len_err"}, 32'(bus.len_err_o),    32'(m_len));
    chk({tag, ".par_err"}, 32'(bus.parity_err_o), 32'(m_par));
  endtask

  task automatic shift_code(input logic [7:0] pat, input int n);
    for (int b = 0; b < n; b++) cyc(0, 1, 0, pat[b], '0);
  endtask

  typedef struct {
    logic [7:0]     pat;
    int             nbits;
    logic [IRW-1:0] code;
    logic [IC-1:0]  onehot;
    bit             ill;
    bit             len;
  } vec_t;

  vec_t tbl[8];

  initial begin
    for (int i = 0; i < IC; i++) opc[i] = (i == 0) ? (1 << IRW) - 1 : (i == 2) ? 0 : i;

    tbl[0] = '{8'h08, 4, 4'h8, 10'b01_0000_0000, 0, 0};
    tbl[1] = '{8'h0B, 4, 4'hF, 10'b00_0000_0001, 1, 0};
    tbl[2] = '{8'h04, 4, 4'h4, 10'b00_0001_0000, 0, 0};
    tbl[3] = '{8'h03, 5, 4'h1, 10'b00_0000_0010, 0, 1};
    tbl[4] = '{8'h00, 4, 4'h0, 10'b00_0000_0100, 0, 0};
    tbl[5] = '{8'h07, 3, 4'hF, 10'b00_0000_0001, 1, 1};
    tbl[6] = '{8'h09, 4, 4'h9, 10'b10_0000_0000, 0, 0};
    tbl[7] = '{8'h05, 4, 4'h5, 10'b00_0010_0000, 0, 0};

    bus.tdi = 0; bus.capture_ir = 0; bus.shift_ir = 0; bus.update_ir = 0; bus.status_i = '0;
    tl_reset = 1'b1;
    #23;
    chk("rst.onehot",  32'(bus.instr_onehot), 32'h010);
    chk("rst.code",    32'(bus.instr_code),   32'h4);
    chk("rst.tdo",     32'(bus.tdo),          32'h0);
    chk("rst.tdo_en",  32'(bus.tdo_en),       32'h0);
    chk("rst.flags",   32'({bus.illegal_o, bus.len_err_o, bus.parity_err_o}), 32'h0);
    tl_reset = 1'b0;
    m_reset();

    // Capture status 2'b10 and watch the captured bits stream out.
    cyc(1, 0, 0, 0, 2'b10);
    chk("cap.tdo0",   32'(bus.tdo),    32'h1);
    chk("cap.tdo_en", 32'(bus.tdo_en), 32'h0);
    cyc(0, 1, 0, 0, '0);
    chk("cap.tdo1",   32'(bus.tdo),    32'h0);
    chk("sh.tdo_en",  32'(bus.tdo_en), 32'h1);
    cyc(0, 1, 0, 0, '0);
    chk("cap.tdo2",   32'(bus.tdo),    32'h0);
    cyc(0, 1, 0, 0, '0);
    chk("cap.tdo3",   32'(bus.tdo),    32'h1);

`ifndef JTAG_IR_PARITY_EN
    for (int i = 0; i < 8; i++) begin
      cyc(1, 0, 0, 0, '0);
      shift_code(tbl[i].pat, tbl[i].nbits);
      cyc(0, 0, 1, 0, '0);
      chk($sformatf("tbl%0d.code", i),    32'(bus.instr_code),   32'(tbl[i].code));
      chk($sformatf("tbl%0d.onehot", i),  32'(bus.instr_onehot), 32'(tbl[i].onehot));
      chk($sformatf("tbl%0d.illegal", i), 32'(bus.illegal_o),    32'(tbl[i].ill));
      chk($sformatf("tbl%0d.len_err", i), 32'(bus.len_err_o),    32'(tbl[i].len));
      chk_all($sformatf("tbl%0d", i));
    end
`else
    cyc(1, 0, 0, 0, '0);
    shift_code(8'h04, 5);
    cyc(0, 0, 1, 0, '0);
    chk("par0.err",  32'(bus.parity_err_o), 32'h1);
    chk("par0.code", 32'(bus.instr_code),   32'hF);
    chk_all("par0");
    cyc(1, 0, 0, 0, '0);
    shift_code(8'h14, 5);
    cyc(0, 0, 1, 0, '0);
    chk("par1.err",    32'(bus.parity_err_o), 32'h0);
    chk("par1.onehot", 32'(bus.instr_onehot), 32'h010);
    chk_all("par1");
`endif

    // Raise a sticky flag, start a shift, then reset in the middle of it.
    cyc(1, 0, 0, 0, '0);
    shift_code(8'h0B, CL);
    cyc(0, 0, 1, 0, '0);
    chk_all("pre_rst");
    cyc(1, 0, 0, 0, 2'b11);
    shift_code(8'h03, 2);
    tl_reset = 1'b1;
    #1;
    chk("midrst.onehot", 32'(bus.instr_onehot), 32'h010);
    chk("midrst.code",   32'(bus.instr_code),   32'h4);
    chk("midrst.tdo",    32'(bus.tdo),          32'h0);
    chk("midrst.flags",  32'({bus.illegal_o, bus.len_err_o, bus.parity_err_o}), 32'h0);
    #1;
    tl_reset = 1'b0;
    m_reset();
    cyc(0, 0, 0, 0, '0);
    chk_all("post_rst");
    shift_code(8'h08, IRW);
    cyc(0, 0, 1, 0, '0);
    chk_all("post_rst_upd");

    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 9) == 0, $urandom_range(0, 9) < 6, $urandom_range(0, 6) == 0,
          1'($urandom), 2'($urandom));
      chk_all($sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
